mult_share_sched: RTL and testbench

- Time-shares one constant-coefficient multiplier (10-bit operand in, 16-bit product out, fixed pipeline latency) among NREQ requesters in the Reed-Solomon datapath.
- Round-robin arbitration selects one operand per cycle and drives it to the multiplier.
- A tag pipeline tracks which requester owns each in-flight operand; each product is returned to its owner with a valid pulse.
- Sits between the syndrome/error-evaluator stages and the single shared multiplier instance.

---
 rtl/mult_share_sched_if.sv | 26 ++
 rtl/mult_share_sched.sv | 95 +++++++++
 tb/tb_mult_share_sched.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_sched_if.sv
// Requester/multiplier/response bundle for the shared constant-coefficient multiplier scheduler.
interface mult_share_sched_if #(
   parameter int NREQ = 4,
   parameter int DW   = 10,
   parameter int RW   = 16
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic [DW-1:0]      mult_dataa;
   logic [RW-1:0]      mult_result;
   logic               rsp_valid;
   logic [2:0]         rsp_id;
   logic [RW-1:0]      rsp_data;
   logic               busy;

   modport slave (
      input  req, req_data, mult_result,
      output gnt, mult_dataa, rsp_valid, rsp_id, rsp_data, busy
   );

   modport master (
      output req, req_data, mult_result,
      input  gnt, mult_dataa, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin time-sharing of one pipelined multiplier among NREQ requesters;
// a tag pipeline routes each product back to the requester that issued it.
module mult_share_sched #(
   parameter int NREQ = 4,
   parameter int DW   = 10,
   parameter int RW   = 16,
   parameter int MLAT = 2
) (
   input logic              clk,
   input logic              reset_n,
   mult_share_sched_if.slave bus
);
   logic [7:0]         req8;
   logic [7:0][DW-1:0] ops;
   logic [2:0]         ptr_q, ptr_d;
   logic [2:0]         gidx;
   logic [3:0]         sum;
   logic               found;
   logic               gnt_vld;
   logic [NREQ-1:0]    gnt_d;

   logic [DW-1:0]        dataa_q;
   logic [MLAT:0]        vld_pipe_q;
   logic [MLAT:0][2:0]   id_pipe_q;
   logic                 rsp_valid_q;
   logic [2:0]           rsp_id_q;
   logic [RW-1:0]        rsp_data_q;

   // Pad to 8 so a 3-bit index is always in range, whatever NREQ is.
   assign req8 = 8'(bus.req);

   always_comb begin
      ops = '0;
      for (int i = 0; i < NREQ; i++) ops[i] = bus.req_data[i*DW +: DW];
   end

   // Scan from the pointer upward, wrapping; first hit wins.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      sum   = '0;
      for (int off = 0; off < NREQ; off++) begin
         sum = {1'b0, ptr_q} + 4'(off);
         if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
         if (!found && req8[sum[2:0]]) begin
            found = 1'b1;
            gidx  = sum[2:0];
         end
      end
   end

   assign gnt_vld = found & reset_n;
   assign gnt_d   = gnt_vld ? NREQ'(8'b1 << gidx) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = (gidx == 3'(NREQ-1)) ? 3'd0 : gidx + 3'd1;
   end

   // Stage 0 of vld_pipe/id_pipe is the issue register; stage MLAT lines up with mult_result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q       <= '0;
         dataa_q     <= '0;
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         ptr_q         <= ptr_d;
         vld_pipe_q[0] <= gnt_vld;
         if (gnt_vld) begin
            dataa_q      <= ops[gidx];
            id_pipe_q[0] <= gidx;
         end
         for (int i = 1; i <= MLAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            id_pipe_q[i]  <= id_pipe_q[i-1];
         end
         rsp_valid_q <= vld_pipe_q[MLAT];
         if (vld_pipe_q[MLAT]) begin
            rsp_data_q <= bus.mult_result;
            rsp_id_q   <= id_pipe_q[MLAT];
         end
      end
   end

   assign bus.gnt        = gnt_d;
   assign bus.mult_dataa = dataa_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.busy       = (|bus.req) | (|vld_pipe_q);
endmodule

// File: tb/tb_mult_share_sched.sv
// Randomised and directed stimulus for mult_share_sched with a queue-based scoreboard
// and a behavioural x32 multiplier of latency 2.
module tb_mult_share_sched;
   localparam int NREQ = 4;
   localparam int DW   = 10;
   localparam int RW   = 16;
   localparam int MLAT = 2;
   localparam int LAT  = MLAT + 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mult_share_sched_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

   mult_share_sched #(.NREQ(NREQ), .DW(DW), .RW(RW), .MLAT(MLAT)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   // External multiplier: product = operand * 32, two register stages.
   logic [RW-1:0] p1, p2;
   always @(posedge clk) begin
      p1 <= RW'(bus.mult_dataa) * 16'd32;
      p2 <= p1;
   end
   assign bus.mult_result = p2;

   typedef struct {
      int            id;
      logic [RW-1:0] data;
      int            due;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: rotating-priority pick, operand capture, busy window, expected responses.
   int            m_ptr = 0;
   logic [DW-1:0] m_dataa = '0;
   logic [2:0]    g_hist = '0;
   initial forever begin
      int g;
      @(negedge clk);
      if (!reset_n) begin
         q.delete();
         m_ptr   = 0;
         m_dataa = '0;
         g_hist  = '0;
         chk("reset_gnt",       32'(bus.gnt), 0);
         chk("reset_dataa",     32'(bus.mult_dataa), 0);
         chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("reset_rsp_id",    32'(bus.rsp_id), 0);
         chk("reset_rsp_data",  32'(bus.rsp_data), 0);
         chk("reset_busy",      32'(bus.busy), 0);
      end else begin
         g = -1;
         chk("mult_dataa", 32'(bus.mult_dataa), 32'(m_dataa));
         chk("busy", 32'(bus.busy), 32'((|bus.req) || (|g_hist)));
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req[j]) g = j;
         end
         chk("gnt", 32'(bus.gnt), (g < 0) ? 32'd0 : (32'd1 << g));
         if (g >= 0) begin
            exp_t e;
            m_dataa = bus.req_data[g*DW +: DW];
            e.id    = g;
            e.data  = RW'(m_dataa) * 16'd32;
            e.due   = cyc + LAT;
            q.push_back(e);
            m_ptr = (g + 1) % NREQ;
         end
         g_hist = {g_hist[1:0], g >= 0};
      end
   end

   // Monitor: every rsp_valid must match the oldest outstanding expectation, on its cycle.
   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 1);
            if (bus.rsp_valid) begin
               chk("rsp_id",   32'(bus.rsp_id), 32'(e.id));
               chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            end
         end else if (bus.rsp_valid) begin
            chk("rsp_valid_spurious", 32'(bus.rsp_valid), 0);
         end
      end
   end

   task automatic drive(input logic [3:0] r, input logic [DW-1:0] d0, d1, d2, d3);
      @(posedge clk);
      #1;
      bus.req      = r;
      bus.req_data = {d3, d2, d1, d0};
   endtask

   task automatic idle(input int n);
      repeat (n) drive(4'b0000, '0, '0, '0, '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      bus.req = '0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [NREQ-1:0] gs;
      bit got;
      int w;
      bus.req      = '0;
      bus.req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Single request, operand 5 from requester 2.
      drive(4'b0100, 10'd0, 10'd0, 10'd5, 10'd0);
      idle(6);

      // All requesters continuously, from pointer 0.
      do_reset();
      repeat (12) drive(4'b1111, 10'd1, 10'd2, 10'd3, 10'd4);
      idle(6);

      // Starvation: req0 held, req3 joins once pointer has moved to 1.
      repeat (5) drive(4'b0001, 10'd9, 10'd0, 10'd0, 10'd0);
      drive(4'b1001, 10'd9, 10'd0, 10'd0, 10'd7);
      got = 1'b0;
      w   = 0;
      while (!got && w < NREQ) begin
         @(negedge clk);
         got = bus.gnt[3];
         if (!got) begin
            w++;
            @(posedge clk);
            #1;
         end
      end
      chk("starve_req3_granted", 32'(got), 1);
      repeat (2) drive(4'b0001, 10'd9, 10'd0, 10'd0, 10'd0);
      idle(6);

      // Extremes and pointer wrap: 3FF from 3, then 0 from 0.
      drive(4'b1000, 10'd0, 10'd0, 10'd0, 10'h3FF);
      drive(4'b0001, 10'd0, 10'd0, 10'd0, 10'd0);
      idle(6);

      // Reset with an operation in flight: nothing may come back; pointer returns to 0.
      drive(4'b0010, 10'd0, 10'h3FF, 10'd0, 10'd0);
      @(posedge clk);
      #1;
      bus.req = '0;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(6);
      drive(4'b1111, 10'd11, 10'd12, 10'd13, 10'd14);
      @(negedge clk);
      chk("post_reset_first_gnt", 32'(bus.gnt), 32'd1);
      idle(6);

      // Random traffic; a requester keeps req and operand until granted.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         gs = bus.gnt;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (!(bus.req[i] && !gs[i])) begin
               bus.req[i] = 1'($urandom_range(0, 1));
               bus.req_data[i*DW +: DW] = DW'($urandom);
            end
         end
      end

      // Drain and stay idle.
      idle(25);
      chk("queue_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
